// File: rtl/cordic_lut_server.sv
// -----------------------------------------------------------------------------
// cordic_lut_server
//
// Shared angle look-up table for several CORDIC controllers. Each channel
// asks for the elementary rotation angle f(2^-i), scaled by 2^(P_WIDTH-2),
// where f is atan (circular), atanh (hyperbolic) or identity (linear). One
// request is accepted per cycle, chosen round-robin among idle channels with
// a pending request. Each channel has at most one transaction in flight. The
// response appears two cycles after acceptance and is held until consumed.
//
// Ports:
//   clk        single clock, rising edge
//   rstN       asynchronous active-low reset
//   reqValid   per-channel request valid
//   reqReady   per-channel request ready (valid & ready = accepted)
//   reqOffset  per-channel iteration index i, P_LOG2_WIDTH bits each
//   reqMode    per-channel mode: 00 circ, 01 hyper, 10 linear, 11 reserved
//   rspValid   per-channel response valid
//   rspReady   per-channel response consumed
//   rspAngle   per-channel signed angle, P_WIDTH bits each
//   rspError   per-channel error flag, qualified by rspValid
//
// Configuration macro:
//   LUT_HYPERBOLIC_EN  compile in the atanh table. Without it, hyperbolic
//                      requests are answered like reserved mode (0, error).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cordic_lut_server #(
  parameter  int P_WIDTH      = 32,
  parameter  int P_CHANNELS   = 2,
  localparam int P_LOG2_WIDTH = $clog2(P_WIDTH)
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic [P_CHANNELS-1:0]              reqValid,
  output logic [P_CHANNELS-1:0]              reqReady,
  input  logic [P_CHANNELS*P_LOG2_WIDTH-1:0] reqOffset,
  input  logic [P_CHANNELS*2-1:0]            reqMode,
  output logic [P_CHANNELS-1:0]              rspValid,
  input  logic [P_CHANNELS-1:0]              rspReady,
  output logic [P_CHANNELS*P_WIDTH-1:0]      rspAngle,
  output logic [P_CHANNELS-1:0]              rspError
);

  localparam int P_CH_W = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;
  localparam logic [P_LOG2_WIDTH-1:0] P_OFF_LIMIT = P_LOG2_WIDTH'(P_WIDTH - 2);

  typedef enum logic [1:0] {
    MODE_CIRC  = 2'b00,
    MODE_HYPER = 2'b01,
    MODE_LIN   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Elaboration-time table generator. Series are summed in 62-bit fixed point
  // and then rounded to the output scale, so the result matches
  // round(f(2^-i) * 2^(P_WIDTH-2)). atan(1) converges too slowly as a series,
  // so pi/4 * 2^62 is given directly. fn: 0 atan, 1 atanh, 2 identity.
  function automatic logic [P_WIDTH-1:0] tableEntry(input int fn, input int idx);
    logic [63:0] acc;
    logic [63:0] term;
    int          e;
    acc = '0;
    if (idx >= P_WIDTH - 2) return '0;
    if (fn == 2) begin
      acc = 64'd1 << (62 - idx);
    end else if (fn == 0 && idx == 0) begin
      acc = 64'h3243_F6A8_885A_308D;
    end else if (!(fn == 1 && idx == 0)) begin
      for (int k = 0; k < 32; k++) begin
        e = 62 - idx * (2 * k + 1);
        if (e >= 0) begin
          term = (64'd1 << e) / 64'(2 * k + 1);
          if (fn == 0 && k[0]) acc = acc - term;
          else                 acc = acc + term;
        end
      end
    end
    acc = acc + (64'd1 << (63 - P_WIDTH));
    return P_WIDTH'(acc >> (64 - P_WIDTH));
  endfunction

  logic [P_WIDTH-1:0] w_atanTab [P_WIDTH];
  logic [P_WIDTH-1:0] w_linTab  [P_WIDTH];
`ifdef LUT_HYPERBOLIC_EN
  logic [P_WIDTH-1:0] w_atanhTab [P_WIDTH];
`endif

  for (genvar g = 0; g < P_WIDTH; g++) begin : g_table
    localparam logic [P_WIDTH-1:0] LP_ATAN = tableEntry(0, g);
    localparam logic [P_WIDTH-1:0] LP_LIN  = tableEntry(2, g);
    assign w_atanTab[g] = LP_ATAN;
    assign w_linTab[g]  = LP_LIN;
`ifdef LUT_HYPERBOLIC_EN
    localparam logic [P_WIDTH-1:0] LP_ATANH = tableEntry(1, g);
    assign w_atanhTab[g] = LP_ATANH;
`endif
  end

  logic [P_CHANNELS-1:0]         r_busy;
  logic [P_CH_W-1:0]             r_rrPtr;
  logic                          r_s1Valid;
  logic [P_CH_W-1:0]             r_s1Chan;
  logic [P_LOG2_WIDTH-1:0]       r_s1Offset;
  mode_e                         r_s1Mode;
  logic [P_CHANNELS-1:0]         r_rspValid;
  logic [P_CHANNELS-1:0]         r_rspError;
  logic [P_CHANNELS*P_WIDTH-1:0] r_rspAngle;

  logic                    w_grantValid;
  logic [P_CH_W-1:0]       w_grantIdx;
  logic [P_CHANNELS-1:0]   w_grantOh;
  logic [P_CH_W-1:0]       w_nextPtr;
  logic [P_WIDTH-1:0]      w_lutAngle;
  logic                    w_lutError;

  // Round-robin search starting at the pointer; first idle requester wins.
  always_comb begin : p_arbiter
    int cand;
    cand         = 0;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_grantOh    = '0;
    w_nextPtr    = r_rrPtr;
    for (int k = 0; k < P_CHANNELS; k++) begin
      cand = int'(r_rrPtr) + k;
      if (cand >= P_CHANNELS) cand = cand - P_CHANNELS;
      if (!w_grantValid && reqValid[P_CH_W'(cand)] && !r_busy[P_CH_W'(cand)]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = P_CH_W'(cand);
      end
    end
    if (w_grantValid) begin
      w_grantOh[w_grantIdx] = 1'b1;
      cand = int'(w_grantIdx) + 1;
      if (cand >= P_CHANNELS) cand = 0;
      w_nextPtr = P_CH_W'(cand);
    end
  end

  // A channel that is not requesting shows its idle status. While it is
  // requesting, ready rises only in the cycle it wins arbitration, so
  // valid & ready is exactly the acceptance. Forced low during reset.
  assign reqReady = {P_CHANNELS{rstN}} & (w_grantOh | (~r_busy & ~reqValid));

  // Table read for the captured request; out-of-range offsets return zero.
  always_comb begin
    w_lutAngle = '0;
    w_lutError = 1'b0;
    case (r_s1Mode)
      MODE_CIRC: if (r_s1Offset < P_OFF_LIMIT) w_lutAngle = w_atanTab[r_s1Offset];
      MODE_LIN:  if (r_s1Offset < P_OFF_LIMIT) w_lutAngle = w_linTab[r_s1Offset];
      MODE_HYPER: begin
`ifdef LUT_HYPERBOLIC_EN
        if (r_s1Offset == '0) begin
          w_lutAngle = {1'b0, {(P_WIDTH-1){1'b1}}};
          w_lutError = 1'b1;
        end else if (r_s1Offset < P_OFF_LIMIT) begin
          w_lutAngle = w_atanhTab[r_s1Offset];
        end
`else
        w_lutError = 1'b1;
`endif
      end
      default: w_lutError = 1'b1;
    endcase
  end

  // Grant capture, busy tracking and response registers. A response slot is
  // only written for a busy channel whose previous response is already gone,
  // so the set and clear of rspValid never collide.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_busy     <= '0;
      r_rrPtr    <= '0;
      r_s1Valid  <= 1'b0;
      r_s1Chan   <= '0;
      r_s1Offset <= '0;
      r_s1Mode   <= MODE_CIRC;
      r_rspValid <= '0;
      r_rspError <= '0;
      r_rspAngle <= '0;
    end else begin
      r_s1Valid <= w_grantValid;
      if (w_grantValid) begin
        r_s1Chan   <= w_grantIdx;
        r_s1Offset <= reqOffset[w_grantIdx*P_LOG2_WIDTH +: P_LOG2_WIDTH];
        r_s1Mode   <= mode_e'(reqMode[w_grantIdx*2 +: 2]);
        r_rrPtr    <= w_nextPtr;
      end
      for (int c = 0; c < P_CHANNELS; c++) begin
        if (r_rspValid[c] && rspReady[c]) begin
          r_rspValid[c] <= 1'b0;
          r_busy[c]     <= 1'b0;
        end
      end
      if (w_grantValid) r_busy[w_grantIdx] <= 1'b1;
      if (r_s1Valid) begin
        r_rspValid[r_s1Chan]                     <= 1'b1;
        r_rspError[r_s1Chan]                     <= w_lutError;
        r_rspAngle[r_s1Chan*P_WIDTH +: P_WIDTH]  <= w_lutAngle;
      end
    end
  end

  assign rspValid = r_rspValid;
  assign rspError = r_rspError;
  assign rspAngle = r_rspAngle;

endmodule

// File: tb/tb_cordic_lut_server.sv
// -----------------------------------------------------------------------------
// tb_cordic_lut_server
//
// Self-checking bench for cordic_lut_server (P_WIDTH=32, P_CHANNELS=2).
// Expected angles come from a real-number model using $atan/$atanh and are
// queued per channel when a request is accepted, then popped when the
// matching response shows up.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cordic_lut_server;

  localparam int W  = 32;
  localparam int C  = 2;
  localparam int LW = 5;

  logic            clk = 1'b0;
  logic            rstN;
  logic [C-1:0]    reqValid;
  logic [C-1:0]    reqReady;
  logic [C*LW-1:0] reqOffset;
  logic [C*2-1:0]  reqMode;
  logic [C-1:0]    rspValid;
  logic [C-1:0]    rspReady;
  logic [C*W-1:0]  rspAngle;
  logic [C-1:0]    rspError;

  typedef struct packed {
    logic [W-1:0] angle;
    logic         err;
  } exp_t;

  exp_t expQ [C][$];
  int   checks = 0;
  int   passes = 0;

  cordic_lut_server #(.P_WIDTH(W), .P_CHANNELS(C)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqOffset (reqOffset),
    .reqMode   (reqMode),
    .rspValid  (rspValid),
    .rspReady  (rspReady),
    .rspAngle  (rspAngle),
    .rspError  (rspError)
  );

  always #5 clk = ~clk;

  // Reference model from real arithmetic.
  function automatic exp_t modelExp(input int mode, input int off);
    exp_t r;
    real  v;
    r.angle = '0;
    r.err   = 1'b0;
    case (mode)
      0: if (off < W-2) begin
           v = $atan(1.0 / (2.0 ** off)) * (2.0 ** (W-2));
           r.angle = W'($rtoi(v + 0.5));
         end
      1: begin
`ifdef LUT_HYPERBOLIC_EN
           if (off == 0) begin
             r.angle = 32'h7FFF_FFFF;
             r.err   = 1'b1;
           end else if (off < W-2) begin
             v = $atanh(1.0 / (2.0 ** off)) * (2.0 ** (W-2));
             r.angle = W'($rtoi(v + 0.5));
           end
`else
           r.err = 1'b1;
`endif
         end
      2: if (off < W-2) begin
           v = 2.0 ** (W-2-off);
           r.angle = W'($rtoi(v + 0.5));
         end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and hold it until accepted; returns in the cycle after
  // the accepting edge with reqValid dropped.
  task automatic applyStimulus(input int ch, input int mode, input int off, output bit ok);
    reqOffset[ch*LW +: LW] = LW'(off);
    reqMode[ch*2 +: 2]     = 2'(mode);
    reqValid[ch]           = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (reqReady[ch]) begin
        expQ[ch].push_back(modelExp(mode, off));
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    reqValid[ch] = 1'b0;
    if (!ok) begin
      checks++;
      $display("[TB] FAIL accept_ch%0d: reqReady never rose within 20 cycles", ch);
    end
  endtask

  task automatic test_reset();
    exp_t dummy;
    rstN      = 1'b0;
    reqValid  = '1;
    rspReady  = '0;
    reqOffset = '0;
    reqMode   = '0;
    #3;
    checks++; if (reqReady !== 2'b00) $display("[TB] FAIL rst_ready: got %b want 00", reqReady); else passes++;
    checks++; if (rspValid !== 2'b00) $display("[TB] FAIL rst_rspValid: got %b want 00", rspValid); else passes++;
    checks++; if (rspAngle !== '0) $display("[TB] FAIL rst_angle: got %h want 0", rspAngle); else passes++;
    checks++; if (rspError !== 2'b00) $display("[TB] FAIL rst_error: got %b want 00", rspError); else passes++;
    step();
    step();
    reqValid = '0;
    rstN     = 1'b1;
    #1;
    checks++; if (reqReady !== 2'b11) $display("[TB] FAIL rst_release_ready: got %b want 11", reqReady); else passes++;
    dummy = '0;
    step();
  endtask

  task automatic test_patterns();
    int   pc [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int   pm [10] = '{0, 0, 1, 1, 2, 3, 0, 0, 2, 1};
    int   po [10] = '{0, 1, 0, 2, 31, 3, 29, 30, 0, 29};
    bit   ok;
    exp_t e;
    logic [W-1:0] got;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(pc[n], pm[n], po[n], ok);
      if (ok) begin
        checks++; if (rspValid[pc[n]] !== 1'b0) $display("[TB] FAIL lat_early_%0d: rspValid=%b want 0", n, rspValid[pc[n]]); else passes++;
        step();
        checks++; if (rspValid[pc[n]] !== 1'b1) $display("[TB] FAIL lat_%0d: rspValid=%b want 1", n, rspValid[pc[n]]); else passes++;
        if (expQ[pc[n]].size() > 0) begin
          e   = expQ[pc[n]].pop_front();
          got = rspAngle[pc[n]*W +: W];
          checks++; if (got !== e.angle) $display("[TB] FAIL angle_%0d (m%0d i%0d): got %h want %h", n, pm[n], po[n], got, e.angle); else passes++;
          checks++; if (rspError[pc[n]] !== e.err) $display("[TB] FAIL err_%0d (m%0d i%0d): got %b want %b", n, pm[n], po[n], rspError[pc[n]], e.err); else passes++;
          if (n == 0) begin
            checks++; if (got !== 32'h3243_F6A9) $display("[TB] FAIL pi_over_4: got %h want 3243f6a9", got); else passes++;
          end
        end
        rspReady[pc[n]] = 1'b1;
        step();
        rspReady[pc[n]] = 1'b0;
        #1;
        checks++; if (rspValid[pc[n]] !== 1'b0) $display("[TB] FAIL clear_%0d: rspValid=%b want 0", n, rspValid[pc[n]]); else passes++;
        checks++; if (reqReady[pc[n]] !== 1'b1) $display("[TB] FAIL idle_%0d: reqReady=%b want 1", n, reqReady[pc[n]]); else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
    step();
    reqOffset = {LW'(2), LW'(1)};
    reqMode   = {2'b10, 2'b00};
    reqValid  = 2'b11;
    #1;
    checks++; if (reqReady !== 2'b01) $display("[TB] FAIL b2b_grant0: reqReady=%b want 01", reqReady); else passes++;
    expQ[0].push_back(modelExp(0, 1));
    step();
    reqValid[0] = 1'b0;
    #1;
    checks++; if (reqReady !== 2'b10) $display("[TB] FAIL b2b_grant1: reqReady=%b want 10", reqReady); else passes++;
    expQ[1].push_back(modelExp(2, 2));
    step();
    reqValid[1] = 1'b0;
    checks++; if (rspValid !== 2'b01) $display("[TB] FAIL b2b_rsp0: rspValid=%b want 01", rspValid); else passes++;
    step();
    checks++; if (rspValid !== 2'b11) $display("[TB] FAIL b2b_rsp1: rspValid=%b want 11", rspValid); else passes++;
    for (int c = 0; c < C; c++) begin
      if (expQ[c].size() > 0) begin
        e = expQ[c].pop_front();
        checks++; if (rspAngle[c*W +: W] !== e.angle) $display("[TB] FAIL b2b_angle%0d: got %h want %h", c, rspAngle[c*W +: W], e.angle); else passes++;
        checks++; if (rspError[c] !== e.err) $display("[TB] FAIL b2b_err%0d: got %b want %b", c, rspError[c], e.err); else passes++;
      end
    end
    rspReady = 2'b11;
    step();
    rspReady = 2'b00;
    checks++; if (rspValid !== 2'b00) $display("[TB] FAIL b2b_drain: rspValid=%b want 00", rspValid); else passes++;
  endtask

  task automatic test_hold();
    bit   ok;
    bit   seen1;
    exp_t e0;
    exp_t e1;
    applyStimulus(0, 0, 3, ok);
    if (ok) begin
      reqOffset[LW +: LW] = LW'(5);
      reqMode[3:2]        = 2'b10;
      reqValid[1]         = 1'b1;
      rspReady[1]         = 1'b1;
      #1;
      checks++; if (reqReady[1] !== 1'b1) $display("[TB] FAIL hold_ch1_grant: reqReady[1]=%b want 1", reqReady[1]); else passes++;
      expQ[1].push_back(modelExp(2, 5));
      step();
      reqValid[1] = 1'b0;
      seen1 = 1'b0;
      e0 = (expQ[0].size() > 0) ? expQ[0].pop_front() : '0;
      for (int k = 0; k < 5; k++) begin
        checks++; if (rspValid[0] !== 1'b1) $display("[TB] FAIL hold_valid_%0d: got %b want 1", k, rspValid[0]); else passes++;
        checks++; if (rspAngle[W-1:0] !== e0.angle) $display("[TB] FAIL hold_angle_%0d: got %h want %h", k, rspAngle[W-1:0], e0.angle); else passes++;
        checks++; if (reqReady[0] !== 1'b0) $display("[TB] FAIL hold_ready_%0d: got %b want 0", k, reqReady[0]); else passes++;
        if (rspValid[1] && !seen1 && expQ[1].size() > 0) begin
          seen1 = 1'b1;
          e1 = expQ[1].pop_front();
          checks++; if (rspAngle[W +: W] !== e1.angle) $display("[TB] FAIL hold_ch1_angle: got %h want %h", rspAngle[W +: W], e1.angle); else passes++;
        end
        step();
      end
      rspReady[1] = 1'b0;
      checks++; if (seen1 !== 1'b1) $display("[TB] FAIL hold_ch1_served: served=%b want 1", seen1); else passes++;
      rspReady[0] = 1'b1;
      step();
      rspReady[0] = 1'b0;
      #1;
      checks++; if (rspValid[0] !== 1'b0) $display("[TB] FAIL hold_release: rspValid[0]=%b want 0", rspValid[0]); else passes++;
      checks++; if (reqReady[0] !== 1'b1) $display("[TB] FAIL hold_idle: reqReady[0]=%b want 1", reqReady[0]); else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    bit seenRsp;
    applyStimulus(0, 0, 4, ok);
    rstN = 1'b0;
    #1;
    checks++; if (reqReady !== 2'b00) $display("[TB] FAIL mid_rst_ready: got %b want 00", reqReady); else passes++;
    expQ[0].delete();
    step();
    rstN = 1'b1;
    seenRsp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rspValid !== 2'b00) seenRsp = 1'b1;
      if (k == 1) begin
        checks++; if (reqReady !== 2'b11) $display("[TB] FAIL mid_rst_ready_after: got %b want 11", reqReady); else passes++;
      end
    end
    checks++; if (seenRsp !== 1'b0) $display("[TB] FAIL mid_rst_discard: rsp seen=%b want 0", seenRsp); else passes++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_hold();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cordic_lut_server.md
CORDIC_LUT_SERVER -- requirements
Module: cordic_lut_server

Interface
REQ-001 SHALL provide parameter P_WIDTH, default 32: angle word width in bits; legal range 8..32.
REQ-002 SHALL provide parameter P_CHANNELS, default 2: number of requesting CORDIC controllers; legal range 1..8.
REQ-003 SHALL derive localparam P_LOG2_WIDTH = clog2(P_WIDTH): offset width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rstN  input  1  reset, asynchronous assert, active-low.
REQ-006 reqValid  input  P_CHANNELS  per-channel request valid.
REQ-007 reqReady  output  P_CHANNELS  per-channel request accepted this cycle when high together with reqValid.
REQ-008 reqOffset  input  P_CHANNELS*P_LOG2_WIDTH  iteration index i per channel, unsigned.
REQ-009 reqMode  input  P_CHANNELS*2  per channel: 00 circular, 01 hyperbolic, 10 linear, 11 reserved.
REQ-010 rspValid  output  P_CHANNELS  per-channel response valid.
REQ-011 rspReady  input  P_CHANNELS  per-channel response consumed when high with rspValid.
REQ-012 rspAngle  output  P_CHANNELS*P_WIDTH  signed angle per channel.
REQ-013 rspError  output  P_CHANNELS  per-channel error flag, qualified by rspValid.

Function
REQ-014 Table values SHALL equal round(f(2^-i) * 2^(P_WIDTH-2)), with f = atan (circular), atanh (hyperbolic), identity (linear).
REQ-015 Each channel SHALL have at most one outstanding transaction; reqReady[c] low from acceptance until its response handshakes.
REQ-016 Per cycle, at most one request SHALL be granted, chosen round-robin among channels with reqValid high and idle.
REQ-017 Round-robin pointer SHALL advance to the channel after the granted one; unchanged when nothing granted.
REQ-018 Pipeline: cycle N grant and capture offset/mode; N+1 table read; rspValid[c] high from cycle N+2.
REQ-019 Response SHALL hold rspAngle/rspError stable while rspValid high and rspReady low.
REQ-020 Response handshake at cycle M SHALL clear rspValid at M+1; a new request on that channel may be granted no earlier than M+1.
REQ-021 Offset i >= P_WIDTH-2 in any valid mode SHALL return 0 with rspError low.
REQ-022 Hyperbolic with i = 0 SHALL return the max positive value (0111..1) with rspError high.
REQ-023 Mode 11 SHALL return 0 with rspError high.
REQ-024 Requests from different channels SHALL be pipelined back-to-back: one grant per cycle sustained.
REQ-025 Inputs on a channel not granted SHALL be ignored; requester holds them until reqReady.

Reset
REQ-026 On rstN low, asynchronously: rspValid = 0, rspError = 0, rspAngle = 0, pipeline valids = 0, all channels idle, round-robin pointer = channel 0.
REQ-027 reqReady SHALL be 0 while rstN low and equal to reqValid-independent idle status after release.
REQ-028 Reset asserted mid-transaction SHALL discard all in-flight requests without producing responses.

Configuration
REQ-029 Macro LUT_HYPERBOLIC_EN: when defined, atanh table compiled in and REQ-022 applies.
REQ-030 Without LUT_HYPERBOLIC_EN, mode 01 SHALL behave as mode 11 (return 0, rspError high); no atanh table instantiated.

Verification
REQ-031 P_WIDTH=32, ch0 circular i=0 -> rspAngle 0x3243F6A9 (pi/4 scaled 2^30) two cycles after grant, rspError 0.
REQ-032 ch0 and ch1 reqValid together, pointer 0 -> ch0 granted cycle N, ch1 granted N+1, responses at N+2 and N+3.
REQ-033 ch0 hyperbolic i=0 -> 0x7FFFFFFF, rspError 1 (with macro); 0, rspError 1 (without macro).
REQ-034 ch0 rspReady held low 5 cycles -> rspAngle stable, reqReady[0] low throughout, ch1 continues to be served.
REQ-035 rstN pulsed low the cycle after a grant -> no rspValid ever asserted for it; reqReady all high two cycles after release.
REQ-036 linear i=31, mode 11 i=3 -> both 0; rspError 0 and 1 respectively.
